// File: rtl/addsub_serial.sv
// ============================================================================
// addsub_serial -- slice-serial adder / subtractor
//
// Adds or subtracts two WIDTH-bit operands, SLICE bits per clock, starting at
// the LSB slice. A start request captures the operands. RB is inverted and the
// carry is preset to 1 for subtraction, so the datapath computes RA + ~RB + 1.
// After N = WIDTH/SLICE RUN cycles the result and carry are registered, and
// done pulses for one cycle.
//
// WIDTH must be an integer multiple of SLICE. SLICE == WIDTH gives a single
// RUN cycle.
//
// Optional feature: define ADDSUB_SERIAL_FLAGS_EN to add the registered status
// outputs zero, negative and overflow. Each one updates together with RC.
// ============================================================================

module addsub_serial #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] RA,
    input  logic [WIDTH-1:0] RB,
    output logic [WIDTH-1:0] RC,
    output logic             carry_out,
    output logic             busy,
    output logic             done
`ifdef ADDSUB_SERIAL_FLAGS_EN
    ,
    output logic             zero,
    output logic             negative,
    output logic             overflow
`endif
);

    // Number of RUN cycles, and a counter wide enough to index them.
    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;

    // Captured operands. op_b already holds ~RB for subtraction.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    // Partial result that is built one slice at a time.
    logic [WIDTH-1:0] acc;
    // Carry between slices.
    logic             carry;
    logic [CNT_W-1:0] slice_cnt;

    // Datapath for the current slice.
    int               slice_lsb;
    logic [SLICE-1:0] slice_a;
    logic [SLICE-1:0] slice_b;
    logic [SLICE-1:0] slice_sum;
    logic             slice_cout;
    // acc with the current slice merged in. This is the full result on the
    // last RUN cycle.
    logic [WIDTH-1:0] result;

    // Ripple-carry full adder over one slice, then merge it into the partial result.
    always_comb begin
        logic c;
        // NOTE: every variable assigned here gets a value before any
        // conditional or loop path, so no latch can be inferred.
        slice_lsb  = int'(slice_cnt) * SLICE;
        slice_a    = op_a[slice_lsb +: SLICE];
        slice_b    = op_b[slice_lsb +: SLICE];
        slice_sum  = '0;
        c          = carry;
        for (int i = 0; i < SLICE; i++) begin
            slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
            c            = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
        end
        slice_cout = c;
        result     = acc;
        result[slice_lsb +: SLICE] = slice_sum;
    end

    // Control FSM, operand capture, slice accumulation and registered outputs.
    always_ff @(posedge clock or posedge clear) begin
        // NOTE: every register here, including the operand and accumulator
        // storage, is cleared by reset. An aborted operation must leave no
        // state behind.
        if (clear) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            slice_cnt <= '0;
            RC        <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef ADDSUB_SERIAL_FLAGS_EN
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // reads the pre-edge value of every other register.
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a      <= RA;
                        op_b      <= sub ? ~RB : RB;
                        carry     <= sub;
                        acc       <= '0;
                        slice_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end else begin
                        state     <= IDLE;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here.
                    acc   <= result;
                    carry <= slice_cout;
                    if (slice_cnt == LAST_SLICE) begin
                        RC        <= result;
                        carry_out <= slice_cout;
`ifdef ADDSUB_SERIAL_FLAGS_EN
                        zero      <= (result == '0);
                        negative  <= result[WIDTH-1];
                        // Signed overflow: both effective addends have the
                        // same sign and the sum has the other sign.
                        overflow  <= (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                                     (result[WIDTH-1] != op_a[WIDTH-1]);
`endif
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end else begin
                        slice_cnt <= slice_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_addsub_serial.sv
// ============================================================================
// tb_addsub_serial -- self-checking bench for addsub_serial (WIDTH=32, SLICE=8)
//
// The stimulus process issues operations and pushes the expected response
// into a queue. The expected response comes from a plain-arithmetic model.
// A monitor pops one entry and compares it each time done is seen.
// Define ADDSUB_SERIAL_FLAGS_EN to also check the status flags.
// ============================================================================

module tb_addsub_serial;

    localparam int WIDTH = 32;
    localparam int SLICE = 8;
    localparam int N     = WIDTH / SLICE;

    logic             clock = 1'b0;
    logic             clear = 1'b1;
    logic             start = 1'b0;
    logic             sub   = 1'b0;
    logic [WIDTH-1:0] RA    = '0;
    logic [WIDTH-1:0] RB    = '0;
    logic [WIDTH-1:0] RC;
    logic             carry_out;
    logic             busy;
    logic             done;
`ifdef ADDSUB_SERIAL_FLAGS_EN
    logic             zero;
    logic             negative;
    logic             overflow;
`endif

    addsub_serial #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clock     (clock),
        .clear     (clear),
        .start     (start),
        .sub       (sub),
        .RA        (RA),
        .RB        (RB),
        .RC        (RC),
        .carry_out (carry_out),
        .busy      (busy),
        .done      (done)
`ifdef ADDSUB_SERIAL_FLAGS_EN
        ,
        .zero      (zero),
        .negative  (negative),
        .overflow  (overflow)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rc;
        logic        co;
        logic        z;
        logic        n;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   compared   = 0;
    int   mismatched = 0;
    int   issued     = 0;
    int   done_count = 0;
    logic prev_done  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model using whole-number arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
        exp_t   e;
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint r;
        longint sr;
        if (s) begin
            r    = ua - ub;
            e.co = (ua >= ub);           // no borrow
            sr   = sa - sb;
        end else begin
            r    = ua + ub;
            e.co = (r >= 64'h1_0000_0000);
            sr   = sa + sb;
        end
        e.rc = r[31:0];
        e.z  = (e.rc == 32'h0);
        e.n  = e.rc[31];
        e.v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return e;
    endfunction

    // Monitor: compare against the scoreboard whenever done is presented.
    always @(negedge clock) begin
        if (!clear) begin
            if (prev_done)
                check("done_one_cycle", {63'd0, done}, 64'd0);
            if (done) begin
                exp_t e;
                done_count++;
                check("done_expected", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("RC", {32'd0, RC}, {32'd0, e.rc});
                    check("carry_out", {63'd0, carry_out}, {63'd0, e.co});
`ifdef ADDSUB_SERIAL_FLAGS_EN
                    check("zero", {63'd0, zero}, {63'd0, e.z});
                    check("negative", {63'd0, negative}, {63'd0, e.n});
                    check("overflow", {63'd0, overflow}, {63'd0, e.v});
`endif
                end
            end
        end
        prev_done = done;
    end

    // Drive a one-cycle start pulse (call at a negedge) and optionally score it.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
        RA    = a;
        RB    = b;
        sub   = s;
        start = 1'b1;
        if (push) begin
            last_exp = model(a, b, s);
            exp_q.push_back(last_exp);
            issued++;
        end
        @(negedge clock);
        start = 1'b0;
        // Scramble the inputs so that a re-sample would be caught.
        RA    = $urandom;
        RB    = $urandom;
        sub   = 1'($urandom_range(0, 1));
    endtask

    // Wait for done with a bound, counting busy cycles on the way. Returns at
    // the negedge where done is high.
    task automatic wait_done(output int busy_cycles);
        bit seen = 0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            if (busy) busy_cycles++;
            @(negedge clock);
        end
        check("done_within_bound", {63'd0, seen}, 64'd1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
        int bc;
        start_op(a, b, s, 1);
        wait_done(bc);
        check({tag, "_busy_cycles"}, 64'(bc), 64'(N));
    endtask

    initial begin
        int bc;
        logic [31:0] a;
        logic [31:0] b;

        // Reset state.
        #1;
        check("reset_RC", {32'd0, RC}, 64'd0);
        check("reset_carry_out", {63'd0, carry_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        repeat (2) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);

        // Directed cases.
        run_op(32'd5, 32'd3, 1'b1, "5m3");
        run_op(32'd3, 32'd5, 1'b1, "3m5");
        run_op(32'hFFFF_FFFF, 32'd1, 1'b0, "ffp1");
        run_op(32'h7FFF_FFFF, 32'd1, 1'b0, "7fp1");
        @(negedge clock);

        // RC and carry_out hold after completion.
        repeat (3) @(negedge clock);
        check("hold_RC", {32'd0, RC}, {32'd0, last_exp.rc});
        check("hold_carry_out", {63'd0, carry_out}, {63'd0, last_exp.co});

        // A start during RUN is ignored.
        start_op(32'd10, 32'd4, 1'b0, 1);
        RA = 32'd1; RB = 32'd1; sub = 1'b0; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(bc);
        check("ignored_start_busy", 64'(bc), 64'(N - 1));
        repeat (8) @(negedge clock);
        check("ignored_start_no_extra_done", 64'(done_count), 64'(issued));

        // Clear in the second RUN cycle aborts the operation.
        start_op(32'd100, 32'd50, 1'b0, 0);   // first RUN cycle now
        @(negedge clock);                      // second RUN cycle
        check("pre_clear_busy", {63'd0, busy}, 64'd1);
        #1 clear = 1'b1;
        #1;
        check("clear_busy", {63'd0, busy}, 64'd0);
        check("clear_RC", {32'd0, RC}, 64'd0);
        check("clear_carry_out", {63'd0, carry_out}, 64'd0);
        check("clear_done", {63'd0, done}, 64'd0);
        @(negedge clock);
        clear = 1'b0;
        repeat (8) @(negedge clock);
        check("abort_no_done", 64'(done_count), 64'(issued));
        run_op(32'd7, 32'd2, 1'b1, "7m2");

        // Random back-to-back operations, restarting straight from DONE.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'hFFFF_FFFF;
                1:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       b = 32'h7FFF_FFFF;
                1:       b = a;
                default: b = $urandom;
            endcase
            run_op(a, b, 1'($urandom_range(0, 1)), "rand");
        end

        repeat (6) @(negedge clock);
        check("hold_RC_final", {32'd0, RC}, {32'd0, last_exp.rc});
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("done_count", 64'(done_count), 64'(issued));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/addsub_serial.md
ADDSUB_SERIAL -- requirements
Module: addsub_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 8, bits processed per clock; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 SHALL have port clock  input  1  single clock, rising-edge active.
REQ-004 SHALL have port clear  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  request to begin an operation.
REQ-006 SHALL have port sub  input  1  mode: 0 = RA+RB, 1 = RA-RB.
REQ-007 SHALL have port RA  input  WIDTH  first operand.
REQ-008 SHALL have port RB  input  WIDTH  second operand.
REQ-009 SHALL have port RC  output  WIDTH  registered result.
REQ-010 SHALL have port carry_out  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-011 SHALL have port busy  output  1  operation in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse, RC/flags valid.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 In IDLE or DONE with start=1, SHALL capture RA, RB (or ~RB when sub=1) into internal registers, set internal carry to sub, clear slice counter, and enter RUN.
REQ-015 In RUN, SHALL add one SLICE-bit slice per cycle, LSB slice first, using full-adder sum/carry per bit, carrying between slices through the internal carry register.
REQ-016 SHALL enter DONE after exactly N = WIDTH/SLICE RUN cycles; done SHALL be 1 for the single cycle in DONE.
REQ-017 Latency: start sampled at edge k gives done=1 in the cycle following edge k+N.
REQ-018 RC and carry_out SHALL update only on the transition into DONE and hold until the next completion or reset.
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 start while in RUN SHALL be ignored; operands and mode SHALL not be re-sampled.
REQ-021 DONE with start=0 SHALL return to IDLE next cycle.
REQ-022 Result SHALL be modulo 2^WIDTH; subtraction SHALL equal RA + ~RB + 1.
REQ-023 SLICE = WIDTH SHALL give N = 1 (single-cycle RUN).

Reset
REQ-024 clear=1 SHALL asynchronously force IDLE and RC=0, carry_out=0, busy=0, done=0, internal registers and counter to 0, including mid-operation; the aborted operation SHALL produce no done.
REQ-025 The first start after clear deasserts SHALL behave as from IDLE.

Configuration
REQ-026 With macro ADDSUB_SERIAL_FLAGS_EN defined, SHALL add outputs zero (RC==0), negative (RC[WIDTH-1]) and overflow (signed overflow of the operation), each 1 bit, registered and updated with RC, reset to 0.
REQ-027 Without ADDSUB_SERIAL_FLAGS_EN, these three ports and their logic SHALL be absent; all other behaviour identical.

Verification (WIDTH=32, SLICE=8)
REQ-028 RA=5, RB=3, sub=1, start pulse -> busy 4 cycles, done pulse, RC=0x00000002, carry_out=1.
REQ-029 RA=3, RB=5, sub=1 -> RC=0xFFFFFFFE, carry_out=0, negative=1 (flags build).
REQ-030 RA=0xFFFFFFFF, RB=1, sub=0 -> RC=0x00000000, carry_out=1, zero=1, overflow=0.
REQ-031 RA=0x7FFFFFFF, RB=1, sub=0 -> RC=0x80000000, carry_out=0, overflow=1, negative=1.
REQ-032 start with RA=10, RB=4, sub=0, then start with RA=1, RB=1 during RUN -> single done, RC=0x0000000E.
REQ-033 clear asserted in 2nd RUN cycle -> busy=0, RC=0, no done; following start RA=7, RB=2, sub=1 -> RC=0x00000005.
